// File: rtl/uart_fifo_if.sv
// uart_fifo_if: CPU bus and serial pins of the FIFO UART
interface uart_fifo_if;
  logic cs, rw, rs0, rs1;
  logic [7:0] data_in, data_out;
  logic rx, tx, irq;
  modport master(output cs, rw, rs0, rs1, data_in, rx, input data_out, tx, irq);
  modport slave(input cs, rw, rs0, rs1, data_in, rx, output data_out, tx, irq);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: 6551-style memory-mapped UART with TX/RX FIFOs, parity, stop bits, RX threshold and loopback
module uart_fifo_buf #(parameter int depth = 16) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic [$clog2(depth):0]   count
);
  localparam int aw = $clog2(depth);
  logic [7:0] mem_q [depth];
  logic [aw-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [aw:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // a push into a full FIFO still lands when the same edge pops
  assign do_pop = pop && cnt_q != '0;
  assign do_push = push && (cnt_q != (aw+1)'(depth) || do_pop);
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    wr_d = flush ? '0 : wr_q + aw'(do_push);
    rd_d = flush ? '0 : rd_q + aw'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (aw+1)'(do_push) - (aw+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push && !flush) mem_q[wr_q] <= wdata;
endmodule

module uart_fifo #(
  parameter int clk_freq_hz = 27_000_000,
  parameter int baud_rate   = 115200,
  parameter int oversample  = 16,
  parameter int fifo_depth  = 16,
  parameter int data_bits   = 8
) (
  input logic       clk,
  input logic       rst,
  uart_fifo_if.slave bus
);
  localparam int div0 = clk_freq_hz / (baud_rate * oversample);
  localparam int div = div0 < 1 ? 1 : div0;
  localparam int bw = div > 1 ? $clog2(div) : 1;
  localparam int ow = $clog2(oversample);
  localparam int aw = $clog2(fifo_depth);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} st_t;
  logic [bw-1:0] baud_q, baud_d;
  logic [5:0] cmd_q, cmd_d;
  logic [4:0] ctl_q, ctl_d;
  logic pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d, irq_q, irq_d, line_q, line_d;
  logic [7:0] dout_q, dout_d, status, mask, tx_head, rx_head;
  logic [aw:0] tx_cnt, rx_cnt;
  logic tick, rd, wr, preset, clr, par_en, tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, rx_push, rx_pop, tx_push, tx_end, tx_load, rx_end, rx_half, rx_in;
  logic set_pe, set_fe, set_ovr;
  logic [1:0] addr, sync_q;
  st_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [ow-1:0] tx_tc_q, tx_tc_d, rx_tc_q, rx_tc_d;
  logic [2:0] tx_n_q, tx_n_d, rx_n_q, rx_n_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_bit_q, tx_bit_d, tx_par_q, tx_par_d;
  assign addr = {bus.rs1, bus.rs0};
  assign rd = bus.cs && bus.rw;
  assign wr = bus.cs && !bus.rw;
  assign preset = wr && addr == 2'd1;
  assign clr = rd && addr == 2'd1;
  assign tx_push = wr && addr == 2'd0;
  assign rx_pop = rd && addr == 2'd0;
  assign mask = 8'hFF >> (8 - data_bits);
  assign par_en = cmd_q[4] ^ cmd_q[3];
  assign tick = baud_q == bw'(div - 1);
  assign tx_empty = tx_cnt == '0;
  assign tx_full = tx_cnt == (aw+1)'(fifo_depth);
  assign rx_empty = rx_cnt == '0;
  assign rx_full = rx_cnt == (aw+1)'(fifo_depth);
  assign rx_in = sync_q[1];
  assign status = {~irq_q, rx_full, tx_empty && tx_st_q == IDLE, !tx_full, !rx_empty, ovr_q, fe_q, pe_q};
  assign bus.data_out = dout_q;
  assign bus.tx = line_q;
  assign bus.irq = irq_q;
  uart_fifo_buf #(.depth(fifo_depth)) u_txf (.clk(clk), .rst(rst), .flush(preset), .push(tx_push),
    .pop(tx_pop), .wdata(bus.data_in & mask), .rdata(tx_head), .count(tx_cnt));
  uart_fifo_buf #(.depth(fifo_depth)) u_rxf (.clk(clk), .rst(rst), .flush(preset), .push(rx_push),
    .pop(rx_pop), .wdata(rx_sh_q), .rdata(rx_head), .count(rx_cnt));
  assign tx_end = tx_tc_q == ow'(oversample - 1);
  assign tx_load = !tx_empty && (tx_st_q == IDLE || (tx_st_q == STOP && tx_end && (!ctl_q[4] || tx_n_q[0])));
  always_comb begin
    tx_st_d = tx_st_q;
    tx_tc_d = tx_tc_q;
    tx_n_d = tx_n_q;
    tx_sh_d = tx_sh_q;
    tx_bit_d = tx_bit_q;
    tx_par_d = tx_par_q;
    tx_pop = 1'b0;
    if (preset) begin
      tx_st_d = IDLE;
      tx_bit_d = 1'b1;
    end else if (tick) begin
      tx_tc_d = tx_end ? '0 : tx_tc_q + 1'b1;
      if (tx_load) begin
        tx_st_d = START;
        tx_pop = 1'b1;
        tx_sh_d = tx_head;
        tx_par_d = ^tx_head ^ ~cmd_q[4];
        tx_tc_d = '0;
        tx_bit_d = 1'b0;
      end else if (tx_st_q != IDLE && tx_end) begin
        case (tx_st_q)
          START: begin
            tx_st_d = DATA;
            tx_n_d = '0;
            tx_bit_d = tx_sh_q[0];
          end
          DATA: begin
            tx_sh_d = tx_sh_q >> 1;
            tx_n_d = tx_n_q + 1'b1;
            tx_bit_d = tx_sh_q[1];
            if (tx_n_q == 3'(data_bits - 1)) begin
              tx_st_d = par_en ? PAR : STOP;
              tx_n_d = '0;
              tx_bit_d = par_en ? tx_par_q : 1'b1;
            end
          end
          PAR: begin
            tx_st_d = STOP;
            tx_bit_d = 1'b1;
          end
          default: begin
            tx_n_d = 3'd1;
            tx_st_d = (!ctl_q[4] || tx_n_q[0]) ? IDLE : STOP;
          end
        endcase
      end
    end
  end
  assign rx_end = rx_tc_q == ow'(oversample - 1);
  assign rx_half = rx_tc_q == ow'(oversample / 2 - 1);
  always_comb begin
    rx_st_d = rx_st_q;
    rx_tc_d = rx_tc_q;
    rx_n_d = rx_n_q;
    rx_sh_d = rx_sh_q;
    rx_push = 1'b0;
    set_pe = 1'b0;
    set_fe = 1'b0;
    set_ovr = 1'b0;
    if (preset) rx_st_d = IDLE;
    else if (rx_st_q == IDLE) begin
      if (!rx_in) begin
        rx_st_d = START;
        rx_tc_d = '0;
        rx_sh_d = '0;
      end
    end else if (tick) begin
      rx_tc_d = rx_end ? '0 : rx_tc_q + 1'b1;
      if (rx_st_q == START && rx_half) begin
        rx_st_d = rx_in ? IDLE : DATA;
        rx_tc_d = '0;
        rx_n_d = '0;
      end else if (rx_st_q != START && rx_end) begin
        case (rx_st_q)
          DATA: begin
            rx_sh_d[rx_n_q] = rx_in;
            rx_n_d = rx_n_q + 1'b1;
            if (rx_n_q == 3'(data_bits - 1)) rx_st_d = par_en ? PAR : STOP;
          end
          PAR: begin
            set_pe = rx_in != (^rx_sh_q ^ ~cmd_q[4]);
            rx_st_d = STOP;
          end
          default: begin
            rx_push = 1'b1;
            set_fe = !rx_in;
            set_ovr = rx_full && !rx_pop;
            rx_st_d = IDLE;
          end
        endcase
      end
    end
  end
  always_comb begin
    baud_d = tick ? '0 : baud_q + 1'b1;
    cmd_d = preset ? '0 : (wr && addr == 2'd2) ? bus.data_in[5:0] : cmd_q;
    ctl_d = preset ? '0 : (wr && addr == 2'd3) ? bus.data_in[4:0] : ctl_q;
    pe_d = !preset && (set_pe || (pe_q && !clr));
    fe_d = !preset && (set_fe || (fe_q && !clr));
    ovr_d = !preset && (set_ovr || (ovr_q && !clr));
    irq_d = ~((cmd_q[0] && tx_empty) || (cmd_q[1] && 9'(rx_cnt) >= 9'(ctl_q[3:0]) + 9'd1) ||
              (cmd_q[2] && (pe_q || fe_q || ovr_q)));
    line_d = tx_bit_d || cmd_d[5];
    dout_d = !rd ? dout_q : addr == 2'd0 ? (rx_empty ? 8'h00 : rx_head) : addr == 2'd1 ? status :
             addr == 2'd2 ? {2'b00, cmd_q} : {3'b000, ctl_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q <= '0;
      cmd_q <= '0;
      ctl_q <= '0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      ovr_q <= 1'b0;
      irq_q <= 1'b1;
      line_q <= 1'b1;
      dout_q <= '0;
      sync_q <= 2'b11;
      tx_st_q <= IDLE;
      tx_tc_q <= '0;
      tx_n_q <= '0;
      tx_sh_q <= '0;
      tx_bit_q <= 1'b1;
      tx_par_q <= 1'b0;
      rx_st_q <= IDLE;
      rx_tc_q <= '0;
      rx_n_q <= '0;
      rx_sh_q <= '0;
    end else begin
      baud_q <= baud_d;
      cmd_q <= cmd_d;
      ctl_q <= ctl_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
      ovr_q <= ovr_d;
      irq_q <= irq_d;
      line_q <= line_d;
      dout_q <= dout_d;
      sync_q <= {sync_q[0], cmd_q[5] ? tx_bit_q : bus.rx};
      tx_st_q <= tx_st_d;
      tx_tc_q <= tx_tc_d;
      tx_n_q <= tx_n_d;
      tx_sh_q <= tx_sh_d;
      tx_bit_q <= tx_bit_d;
      tx_par_q <= tx_par_d;
      rx_st_q <= rx_st_d;
      rx_tc_q <= rx_tc_d;
      rx_n_q <= rx_n_d;
      rx_sh_q <= rx_sh_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed scenarios for uart_fifo at 16 clocks per bit
module tb_uart_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  uart_fifo_if bus();
  uart_fifo #(.clk_freq_hz(1_843_200), .baud_rate(115200), .oversample(16), .fifo_depth(16), .data_bits(8))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b1;
    bus.rw = 1'b0;
    {bus.rs1, bus.rs0} = a;
    bus.data_in = d;
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b1;
    bus.rw = 1'b1;
    {bus.rs1, bus.rs0} = a;
    @(negedge clk);
    bus.cs = 1'b0;
    d = bus.data_out;
  endtask

  task automatic bit_out(input logic b);
    @(negedge clk);
    bus.rx = b;
    repeat (15) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] d, input bit par, input logic p);
    bit_out(1'b0);
    for (int j = 0; j < 8; j++) bit_out(d[j]);
    if (par) bit_out(p);
    bit_out(1'b1);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    bus.cs = 1'b0;
    bus.rw = 1'b1;
    bus.rs0 = 1'b0;
    bus.rs1 = 1'b0;
    bus.data_in = 8'h00;
    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", bus.tx); end
    n_chk++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b expected 1", bus.irq); end
    n_chk++;
    if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bus.data_out); end
    rd(2'd1, v);
    n_chk++;
    if (v !== 8'h30) begin n_fail++; $display("FAIL reset_status: got %h expected 30", v); end
  endtask

  task automatic test_tx_frames();
    logic [7:0] exp_c [3];
    logic [9:0] fr;
    logic [7:0] v;
    int t0 = 0;
    bit found = 0;
    exp_c = '{8'h55, 8'hA3, 8'h0F};
    wr(2'd0, exp_c[0]);
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.tx === 1'b0) begin found = 1; t0 = cyc; end
    end
    n_chk++;
    if (!found) begin n_fail++; $display("FAIL tx_start: got no start bit expected one within 50 clk"); end
    else begin
      wr(2'd0, exp_c[1]);
      wr(2'd0, exp_c[2]);
      for (int c = 0; c < 3; c++) begin
        for (int b = 0; b < 10; b++) begin
          while (cyc < t0 + 8 + 16 * (c * 10 + b)) @(negedge clk);
          fr[b] = bus.tx;
        end
        n_chk++;
        if (fr !== {1'b1, exp_c[c], 1'b0})
          begin n_fail++; $display("FAIL tx_frame%0d: got %b expected %b", c, fr, {1'b1, exp_c[c], 1'b0}); end
        if (c == 0) begin
          rd(2'd1, v);
          n_chk++;
          if (v !== 8'h10) begin n_fail++; $display("FAIL tx_busy_status: got %h expected 10", v); end
        end
      end
      while (cyc < t0 + 485) @(negedge clk);
      rd(2'd1, v);
      n_chk++;
      if (v !== 8'h30) begin n_fail++; $display("FAIL tx_idle_status: got %h expected 30", v); end
    end
  endtask

  task automatic test_parity();
    logic [7:0] v;
    wr(2'd2, 8'h10);
    send_char(8'hAA, 1'b1, 1'b0);
    rd(2'd0, v);
    n_chk++;
    if (v !== 8'hAA) begin n_fail++; $display("FAIL par_data0: got %h expected AA", v); end
    rd(2'd1, v);
    n_chk++;
    if (v !== 8'h30) begin n_fail++; $display("FAIL par_good_status: got %h expected 30", v); end
    send_char(8'hAB, 1'b1, 1'b0);
    rd(2'd1, v);
    n_chk++;
    if (v !== 8'h39) begin n_fail++; $display("FAIL par_bad_status: got %h expected 39", v); end
    rd(2'd1, v);
    n_chk++;
    if (v !== 8'h38) begin n_fail++; $display("FAIL par_cleared_status: got %h expected 38", v); end
    rd(2'd0, v);
    n_chk++;
    if (v !== 8'hAB) begin n_fail++; $display("FAIL par_data1: got %h expected AB", v); end
    wr(2'd2, 8'h00);
  endtask

  task automatic test_rx_irq();
    logic [7:0] v;
    logic [7:0] chars [3];
    chars = '{8'h11, 8'h22, 8'h33};
    wr(2'd3, 8'h02);
    wr(2'd2, 8'h02);
    for (int i = 0; i < 3; i++) begin
      send_char(chars[i], 1'b0, 1'b0);
      n_chk++;
      if (bus.irq !== (i < 2 ? 1'b1 : 1'b0))
        begin n_fail++; $display("FAIL irq_after_char%0d: got %b expected %b", i, bus.irq, i < 2); end
    end
    rd(2'd0, v);
    n_chk++;
    if (v !== 8'h11) begin n_fail++; $display("FAIL irq_pop0: got %h expected 11", v); end
    @(negedge clk);
    n_chk++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_release: got %b expected 1", bus.irq); end
    for (int i = 1; i < 3; i++) begin
      rd(2'd0, v);
      n_chk++;
      if (v !== chars[i]) begin n_fail++; $display("FAIL irq_pop%0d: got %h expected %h", i, v, chars[i]); end
    end
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    for (int i = 0; i < 17; i++) send_char(8'(i * 13 + 5), 1'b0, 1'b0);
    rd(2'd1, v);
    n_chk++;
    if (v !== 8'h7C) begin n_fail++; $display("FAIL ovr_status: got %h expected 7C", v); end
    for (int i = 0; i < 16; i++) begin
      rd(2'd0, v);
      n_chk++;
      if (v !== 8'(i * 13 + 5)) begin n_fail++; $display("FAIL ovr_pop%0d: got %h expected %h", i, v, 8'(i * 13 + 5)); end
    end
    rd(2'd1, v);
    n_chk++;
    if (v !== 8'h30) begin n_fail++; $display("FAIL ovr_drained_status: got %h expected 30", v); end
  endtask

  task automatic test_loopback_preset();
    logic [7:0] v;
    int lows = 0;
    wr(2'd2, 8'h20);
    wr(2'd0, 8'h7E);
    repeat (200) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) lows++;
    end
    n_chk++;
    if (lows != 0) begin n_fail++; $display("FAIL loop_pin_low: got %0d low cycles expected 0", lows); end
    rd(2'd0, v);
    n_chk++;
    if (v !== 8'h7E) begin n_fail++; $display("FAIL loop_data: got %h expected 7E", v); end
    wr(2'd3, 8'h05);
    wr(2'd0, 8'h12);
    wr(2'd0, 8'h34);
    repeat (60) @(negedge clk);
    wr(2'd1, 8'h00);
    n_chk++;
    if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL preset_tx: got %b expected 1", bus.tx); end
    rd(2'd1, v);
    n_chk++;
    if (v !== 8'h30) begin n_fail++; $display("FAIL preset_status: got %h expected 30", v); end
    rd(2'd2, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL preset_cmd: got %h expected 00", v); end
    rd(2'd3, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL preset_ctl: got %h expected 00", v); end
    repeat (250) @(negedge clk);
    rd(2'd1, v);
    n_chk++;
    if (v !== 8'h30) begin n_fail++; $display("FAIL preset_quiet_status: got %h expected 30", v); end
  endtask

  initial begin
    test_reset();
    test_tx_frames();
    test_parity();
    test_rx_irq();
    test_overflow();
    test_loopback_preset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
